// File: rtl/dma_axi_s.sv
// AXI4-full slave responder: converts each AXI burst beat into one access on a
// simple native memory interface, one transaction at a time.
module dma_axi_s #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [LEN_W-1:0]    s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [LEN_W-1:0]    s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                valid,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                ready
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam logic [2:0]        SIZE_FULL = 3'($clog2(STRB_W));
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(STRB_W);
    localparam logic [1:0]        BURST_FIXED = 2'b00;
    localparam logic [1:0]        BURST_WRAP  = 2'b10;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RDATA = 3'd3,
        RRESP = 3'd4
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     id_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    cnt_r;
    logic                fixed_r;
    logic                err_r;
    logic                lerr_r;
    logic [DATA_W-1:0]   rdata_r;
    logic                last_beat_s;
    logic [ADDR_W-1:0]   addr_next_s;

    assign last_beat_s = (cnt_r == len_r);
    assign addr_next_s = fixed_r ? addr_r : (addr_r + ADDR_STEP);
    assign address     = addr_r;
    assign s_axi_rdata = rdata_r;

    // Handshake and native-request decode; every valid/ready is forced low during reset.
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = '0;
        s_axi_bresp   = RESP_OKAY;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = '0;
        s_axi_rresp   = RESP_OKAY;
        s_axi_rlast   = 1'b0;
        valid         = 1'b0;
        wdata         = '0;
        wstrb         = '0;
        case (state_r)
            IDLE: begin
                s_axi_awready = ~rst;
                s_axi_arready = ~rst & ~s_axi_awvalid;
            end
            WDATA: begin
                valid        = s_axi_wvalid & ~err_r & ~rst;
                wdata        = s_axi_wdata;
                wstrb        = s_axi_wstrb;
                s_axi_wready = ~rst & (err_r | ready);
            end
            WRESP: begin
                s_axi_bvalid = ~rst;
                s_axi_bid    = id_r;
                s_axi_bresp  = (err_r | lerr_r) ? RESP_SLVERR : RESP_OKAY;
            end
            RDATA: begin
                valid = ~err_r & ~rst;
            end
            RRESP: begin
                s_axi_rvalid = ~rst;
                s_axi_rid    = id_r;
                s_axi_rresp  = err_r ? RESP_SLVERR : RESP_OKAY;
                s_axi_rlast  = last_beat_s;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

    // Transaction FSM: latch the burst, step through its beats, issue the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            id_r    <= '0;
            addr_r  <= '0;
            len_r   <= '0;
            cnt_r   <= '0;
            fixed_r <= 1'b0;
            err_r   <= 1'b0;
            lerr_r  <= 1'b0;
            rdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r  <= '0;
                    lerr_r <= 1'b0;
                    if (s_axi_awvalid) begin
                        id_r    <= s_axi_awid;
                        addr_r  <= s_axi_awaddr;
                        len_r   <= s_axi_awlen;
                        fixed_r <= (s_axi_awburst == BURST_FIXED);
                        err_r   <= (s_axi_awburst == BURST_WRAP) | (s_axi_awsize != SIZE_FULL);
                        state_r <= WDATA;
                    end else if (s_axi_arvalid) begin
                        id_r    <= s_axi_arid;
                        addr_r  <= s_axi_araddr;
                        len_r   <= s_axi_arlen;
                        fixed_r <= (s_axi_arburst == BURST_FIXED);
                        err_r   <= (s_axi_arburst == BURST_WRAP) | (s_axi_arsize != SIZE_FULL);
                        state_r <= RDATA;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WDATA: begin
                    if (s_axi_wvalid && (err_r || ready)) begin
                        // A misplaced wlast is flagged but the burst length still governs.
                        if (s_axi_wlast != last_beat_s) begin
                            lerr_r <= 1'b1;
                        end else begin
                            lerr_r <= lerr_r;
                        end
                        if (last_beat_s) begin
                            state_r <= WRESP;
                        end else begin
                            cnt_r  <= cnt_r + LEN_W'(1);
                            addr_r <= addr_next_s;
                        end
                    end else begin
                        state_r <= WDATA;
                    end
                end
                WRESP: begin
                    if (s_axi_bready) begin
                        lerr_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= WRESP;
                    end
                end
                RDATA: begin
                    if (err_r) begin
                        rdata_r <= '0;
                        state_r <= RRESP;
                    end else if (ready) begin
                        rdata_r <= rdata;
                        state_r <= RRESP;
                    end else begin
                        state_r <= RDATA;
                    end
                end
                RRESP: begin
                    if (s_axi_rready) begin
                        if (last_beat_s) begin
                            state_r <= IDLE;
                        end else begin
                            cnt_r   <= cnt_r + LEN_W'(1);
                            addr_r  <= addr_next_s;
                            state_r <= RDATA;
                        end
                    end else begin
                        state_r <= RRESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
